// File: rtl/reg_file_pkg.sv
// Shared register-file geometry, reused by the decoder and datapath.
// Index 0 is the architectural zero register and never holds state.
package reg_file_pkg;

   localparam int XLEN      = 32;
   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = 5;

   typedef logic [XLEN-1:0]      word_t;
   typedef logic [REG_IDX_W-1:0] regIdx_t;

   function automatic logic isZeroReg(input regIdx_t idx);
      return idx == '0;
   endfunction

endpackage

// File: rtl/reg_file.sv
// Two combinational read ports, one clocked write port, x0 hardwired to zero.
// x1..x31 live in flops so reads stay combinational and reset clears them asynchronously.
module reg_file
   import reg_file_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  readA,
   input  logic [4:0]  readB,
   input  logic        writeEnC,
   input  logic [4:0]  writeC,
   input  logic [31:0] writeDataC,
   output logic [31:0] A,
   output logic [31:0] B
);

   word_t regs [1:NUM_REGS-1];
   logic  writeValid;

   assign writeValid = writeEnC && !isZeroReg(writeC);

   // Registers clear the moment reset rises, so reads see zero throughout reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (writeValid && writeC == REG_IDX_W'(i)) begin
               regs[i] <= writeDataC;
            end
         end
      end
   end

   // No write-to-read bypass: a register being written reads its old value until the edge.
   always_comb begin
      A = '0;
      B = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (readA == REG_IDX_W'(i)) begin
            A = regs[i];
         end
         if (readB == REG_IDX_W'(i)) begin
            B = regs[i];
         end
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file against an array-based reference model.
// Stimulus enqueues expected reads; a separate monitor pops and compares them.
module tb_reg_file;
   import reg_file_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  readA;
   logic [4:0]  readB;
   logic        writeEnC;
   logic [4:0]  writeC;
   logic [31:0] writeDataC;
   logic [31:0] A;
   logic [31:0] B;

   reg_file dut (
      .clk(clk),
      .reset(reset),
      .readA(readA),
      .readB(readB),
      .writeEnC(writeEnC),
      .writeC(writeC),
      .writeDataC(writeDataC),
      .A(A),
      .B(B)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] expA;
      logic [31:0] expB;
   } expect_t;

   expect_t     scoreQ[$];
   event        sampleEv;
   logic [31:0] model [32];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] refRead(input logic [4:0] idx);
      if (reset === 1'b1 || idx == 5'd0) return 32'd0;
      return model[idx];
   endfunction

   function automatic void clearModel();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endfunction

   task automatic applyStimulus(input logic en, input logic [4:0] wIdx,
                                input logic [31:0] wData,
                                input logic [4:0] rA, input logic [4:0] rB);
      writeEnC   = en;
      writeC     = wIdx;
      writeDataC = wData;
      readA      = rA;
      readB      = rB;
   endtask

   task automatic expectReads(input string tag);
      expect_t e;
      #1;
      e.tag  = tag;
      e.expA = refRead(readA);
      e.expB = refRead(readB);
      scoreQ.push_back(e);
      ->sampleEv;
      #1;
   endtask

   task automatic checkOutput(input expect_t e);
      checks++;
      if (A !== e.expA || B !== e.expB) begin
         errors++;
         $display("[TB] FAIL %s: got A=%h B=%h, required A=%h B=%h (readA=%0d readB=%0d)",
                  e.tag, A, B, e.expA, e.expB, readA, readB);
      end
   endtask

   // Checks reads before the edge, lets the model absorb the write, then checks after it.
   task automatic edgeCycle(input string tag);
      expectReads({tag, "_pre"});
      @(posedge clk);
      if (!reset && writeEnC && writeC != 5'd0) model[writeC] = writeDataC;
      expectReads({tag, "_post"});
      @(negedge clk);
   endtask

   initial begin
      forever begin
         @(sampleEv);
         while (scoreQ.size() != 0) checkOutput(scoreQ.pop_front());
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [4:0] wIdx;
      logic [4:0] rA;
      reset = 1'b1;
      clearModel();
      applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
         expectReads("postResetSweep");
      end

      @(negedge clk);
      applyStimulus(1'b0, 5'd1, 32'hAC, 5'd1, 5'd1);
      edgeCycle("enableOff");
      applyStimulus(1'b1, 5'd1, 32'hAC, 5'd1, 5'd1);
      edgeCycle("enableOn");

      for (int i = 2; i < 32; i++) begin
         applyStimulus(1'b0, 5'(i), 32'(i + 7), 5'(i), 5'(i));
         edgeCycle("sweepNoWrite");
         applyStimulus(1'b1, 5'(i), 32'(i + 7), 5'(i), 5'(i));
         edgeCycle("sweepWrite");
      end

      applyStimulus(1'b1, 5'd0, 32'h98, 5'd0, 5'd0);
      edgeCycle("x0Discard");

      applyStimulus(1'b1, 5'd1, 32'h56, 5'd1, 5'd2);
      edgeCycle("backToBack1");
      applyStimulus(1'b1, 5'd2, 32'hC2, 5'd1, 5'd2);
      edgeCycle("backToBack2");

      for (int n = 0; n < 300; n++) begin
         wIdx = 5'($urandom_range(0, 31));
         rA   = ($urandom_range(0, 2) == 0) ? wIdx : 5'($urandom_range(0, 31));
         applyStimulus(1'($urandom_range(0, 1)), wIdx, $urandom, rA,
                       5'($urandom_range(0, 31)));
         edgeCycle("random");
      end

      // Assert reset between edges: contents must vanish before the next clock.
      #2;
      reset = 1'b1;
      clearModel();
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 5'(i), $urandom, 5'(i), 5'(31 - i));
         expectReads("asyncReset");
      end
      @(negedge clk);
      applyStimulus(1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
      edgeCycle("writeDuringReset");

      reset = 1'b0;
      applyStimulus(1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd0);
      edgeCycle("firstWriteAfterReset");

      #2;
      if (scoreQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboardDrain: %0d entries left, required 0", scoreQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
